photon_bin_counter: RTL and testbench

- Downstream consumer of the trigger-interval generator's `ready` pulse (2-cycle-wide, one per interval).
- Counts photon-detector edges between successive trigger pulses. Each trigger pulse closes one bin.
- Closed bin counts are pushed into a small first-word-fall-through FIFO, which the HPS/Avalon slave side drains.

---
 rtl/photon_cnt_pkg.sv | 18 +
 rtl/photon_bin_fifo.sv | 67 ++++++
 rtl/photon_bin_counter.sv | 143 ++++++++++++++
 tb/tb_photon_bin_counter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/photon_cnt_pkg.sv
// Shared types and helpers for the photon bin counter: FSM encoding,
// timestamp width and FIFO level-width helper.
package photon_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam int TS_W = 32;

  // Level must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/photon_bin_fifo.sv
// First-word-fall-through sync FIFO for closed bins. The head is held in a
// register; level/empty/full are registered and updated together.
module photon_bin_fifo
  import photon_cnt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic                      full,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0]    level_d;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign rd_nxt  = rd_ptr + AW'(1);
  assign level_d = level + LW'(push_ok) - LW'(pop_ok);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_nxt;
      level <= level_d;
      empty <= (level_d == '0);
      full  <= (level_d == LW'(DEPTH));
      // Head register: next entry on pop, incoming word when it becomes the head.
      if (pop_ok) begin
        if (level == LW'(1)) begin
          if (push_ok) rdata <= wdata;
        end else begin
          rdata <= mem[rd_nxt];
        end
      end else if (push_ok && empty) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/photon_bin_counter.sv
// Counts synchronized photon edges between trigger events and queues each
// closed bin. Define PHOTON_BIN_TIMESTAMP_EN to add per-bin cycle timestamps.
module photon_bin_counter
  import photon_cnt_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           photon_in,
  input  logic                           trig,
  input  logic                           enable,
  input  logic                           rd,
  input  logic                           clr_ovf,
  output logic [CNT_W-1:0]               rd_data,
  output logic                           fifo_empty,
  output logic                           fifo_full,
  output logic [lvl_w(FIFO_DEPTH)-1:0]   fifo_level,
  output logic                           overflow
`ifdef PHOTON_BIN_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]                bin_ts
`endif
);

`ifdef PHOTON_BIN_TIMESTAMP_EN
  localparam int FW = CNT_W + TS_W;
`else
  localparam int FW = CNT_W;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ph_last, ph_evt;
  logic                   trig_d, trig_evt;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   push, drop;
  logic [FW-1:0]          push_data, fifo_rdata;

  // photon_in is asynchronous: shift through the synchronizer before edge detect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= '0;
      ph_last <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], photon_in};
      ph_last <= sync_q[SYNC_STAGES-1];
      trig_d  <= trig;
    end
  end

  assign ph_evt   = sync_q[SYNC_STAGES-1] & ~ph_last;
  assign trig_evt = trig & ~trig_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (trig_evt) state_d = COUNT;
        COUNT:   state_d = COUNT;
        default: state_d = IDLE;
      endcase
    end
  end

  // A photon coincident with the trigger opens the new bin rather than closing the old one.
  always_comb begin
    cnt_d = '0;
    push  = 1'b0;
    if (enable) begin
      unique case (state_q)
        ARM: if (trig_evt) cnt_d = CNT_W'(ph_evt);
        COUNT: begin
          if (trig_evt) begin
            push  = 1'b1;
            cnt_d = CNT_W'(ph_evt);
          end else if (ph_evt) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

`ifdef PHOTON_BIN_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  assign push_data = {ts_q, cnt_q};
  assign bin_ts    = fifo_rdata[FW-1 -: TS_W];
`else
  assign push_data = cnt_q;
`endif

  assign rd_data = fifo_rdata[CNT_W-1:0];

  photon_bin_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (push_data),
    .pop   (rd),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level),
    .drop  (drop)
  );

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_photon_bin_counter.sv
// Directed bench for photon_bin_counter with a 4-entry FIFO.
module tb_photon_bin_counter;
  import photon_cnt_pkg::*;

  localparam int CNT_W = 32;
  localparam int DEPTH = 4;
  localparam int LW    = lvl_w(DEPTH);

  logic             CLK = 1'b0;
  logic             RST;
  logic             photon_in, trig, enable, rd, clr_ovf;
  logic [CNT_W-1:0] rd_data;
  logic             fifo_empty, fifo_full, overflow;
  logic [LW-1:0]    fifo_level;
`ifdef PHOTON_BIN_TIMESTAMP_EN
  logic [TS_W-1:0]  bin_ts;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  photon_bin_counter #(
    .CNT_W       (CNT_W),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .photon_in  (photon_in),
    .trig       (trig),
    .enable     (enable),
    .rd         (rd),
    .clr_ovf    (clr_ovf),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef PHOTON_BIN_TIMESTAMP_EN
    ,
    .bin_ts     (bin_ts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          n_ph;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic photons(input int n);
    for (int i = 0; i < n; i++) begin
      photon_in = 1'b1; tick(2);
      photon_in = 1'b0; tick(2);
    end
  endtask

  task automatic trig_pulse();
    trig = 1'b1; tick(2);
    trig = 1'b0; tick(1);
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    check(name, 64'(rd_data), 64'(exp));
    rd = 1'b1; tick(1);
    rd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{n_ph: 7,  exp_cnt: 32'd7};
    vecs[1] = '{n_ph: 0,  exp_cnt: 32'd0};
    vecs[2] = '{n_ph: 1,  exp_cnt: 32'd1};
    vecs[3] = '{n_ph: 3,  exp_cnt: 32'd3};
    vecs[4] = '{n_ph: 12, exp_cnt: 32'd12};

    RST = 1'b1; photon_in = 0; trig = 0; enable = 0; rd = 0; clr_ovf = 0;
    tick(3);
    check("rst_level", 64'(fifo_level), 0);
    check("rst_empty", 64'(fifo_empty), 1);
    check("rst_full",  64'(fifo_full), 0);
    check("rst_ovf",   64'(overflow), 0);
    check("rst_data",  64'(rd_data), 0);
    RST = 1'b0; tick(1);

    // Enable without a trigger stays armed and never pushes.
    enable = 1'b1; tick(1);
    photons(5);
    check("arm_state", 64'(dut.state_q), 64'(ARM));
    check("arm_level", 64'(fifo_level), 0);

    // rd while empty is ignored.
    rd = 1'b1; tick(1); rd = 1'b0;
    check("rd_empty_level", 64'(fifo_level), 0);
    check("rd_empty_flag",  64'(fifo_empty), 1);

    trig_pulse();
    check("count_state", 64'(dut.state_q), 64'(COUNT));
    check("count_level", 64'(fifo_level), 0);

    for (int v = 0; v < 5; v++) begin
      photons(vecs[v].n_ph);
      trig_pulse();
      check($sformatf("vec%0d_level", v), 64'(fifo_level), 1);
      check($sformatf("vec%0d_data", v),  64'(rd_data), 64'(vecs[v].exp_cnt));
      rd = 1'b1; tick(1); rd = 1'b0;
      check($sformatf("vec%0d_empty", v), 64'(fifo_empty), 1);
    end

    // Coincidence: ph_evt and trig_evt on the same cycle.
    photons(2);
    photon_in = 1'b1; tick(2);
    trig = 1'b1; photon_in = 1'b0; tick(2);
    trig = 1'b0; tick(1);
    photons(2);
    trig_pulse();
    check("coin_level", 64'(fifo_level), 2);
    pop_check("coin_bin_a", 2);
    pop_check("coin_bin_b", 3);
    check("coin_empty", 64'(fifo_empty), 1);

    // Overflow: five bins into a four-entry FIFO.
    for (int k = 1; k <= 5; k++) begin
      photons(k);
      trig_pulse();
    end
    check("ovf_full",  64'(fifo_full), 1);
    check("ovf_level", 64'(fifo_level), 4);
    check("ovf_flag",  64'(overflow), 1);
    check("ovf_head",  64'(rd_data), 1);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    check("ovf_clr", 64'(overflow), 0);

    // Push and pop together while full.
    photons(6);
    trig = 1'b1; rd = 1'b1; tick(1);
    rd = 1'b0; tick(1); trig = 1'b0; tick(1);
    check("pp_level", 64'(fifo_level), 4);
    check("pp_ovf",   64'(overflow), 0);
    check("pp_full",  64'(fifo_full), 1);
    pop_check("pp_e0", 2);
    pop_check("pp_e1", 3);
    pop_check("pp_e2", 4);
    pop_check("pp_e3", 6);
    check("pp_empty", 64'(fifo_empty), 1);

    // Disable mid-bin discards the partial count.
    photons(3);
    enable = 1'b0; tick(1);
    check("abort_state", 64'(dut.state_q), 64'(IDLE));
    check("abort_level", 64'(fifo_level), 0);
    enable = 1'b1; tick(1);
    check("rearm_state", 64'(dut.state_q), 64'(ARM));
    photons(2);
    trig_pulse();
    photons(1);
    trig_pulse();
    check("rearm_level", 64'(fifo_level), 1);
    check("rearm_data",  64'(rd_data), 1);

    // Async reset mid-bin, sampled between clock edges.
    photons(2);
    @(posedge CLK); #3;
    RST = 1'b1; #1;
    check("arst_level", 64'(fifo_level), 0);
    check("arst_empty", 64'(fifo_empty), 1);
    check("arst_data",  64'(rd_data), 0);
    check("arst_state", 64'(dut.state_q), 64'(IDLE));
    tick(1);
    RST = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
